// File: rtl/bit32_demux1to2_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit32_demux1to2_stream_pkg
// Brief    : Shared defaults and select encodings for the 1-to-2 stream demux.
// Revision : 1.0 - initial release
// ============================================================================
package bit32_demux1to2_stream_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  // in_sel encodings naming the destination port
  localparam logic SEL_PORT0 = 1'b0;
  localparam logic SEL_PORT1 = 1'b1;

endpackage : bit32_demux1to2_stream_pkg
`default_nettype wire

// File: rtl/bit32_demux1to2_stream_demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_out_slot
// Brief    : One output port of the demux: a single registered data/valid slot
//            with load/drain handling and a wrapping transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module demux_out_slot
  import bit32_demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  logic xfer;

  assign xfer = valid && ready;

  // Slot register: a load always wins (covers drain-and-refill); a drain alone empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

  // Count completed transfers on this port; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : demux_out_slot
`default_nettype wire

// File: rtl/bit32_demux1to2_stream.sv
`default_nettype none
// ============================================================================
// Module   : bit32_demux1to2_stream
// Brief    : 1-to-2 valid/ready stream demultiplexer. Each input word is
//            steered by in_sel into one of two registered output slots.
// Revision : 1.0 - initial release
// ============================================================================
module bit32_demux1to2_stream
  import bit32_demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic accept;
  logic load0;
  logic load1;

  // Readiness looks only at the selected port, so a stalled port never blocks the other one.
  always_comb begin
    in_ready = 1'b0;
    if (in_sel == SEL_PORT1) begin
      in_ready = !out1_valid || out1_ready;
    end else begin
      in_ready = !out0_valid || out0_ready;
    end
  end

  assign accept = in_valid && in_ready;
  assign load0  = accept && (in_sel == SEL_PORT0);
  assign load1  = accept && (in_sel == SEL_PORT1);

  demux_out_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (in_data),
    .ready     (out0_ready),
    .data      (out0_data),
    .valid     (out0_valid),
    .cnt       (cnt0)
  );

  demux_out_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (in_data),
    .ready     (out1_ready),
    .data      (out1_data),
    .valid     (out1_valid),
    .cnt       (cnt1)
  );

endmodule : bit32_demux1to2_stream
`default_nettype wire

// File: tb/tb_bit32_demux1to2_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit32_demux1to2_stream
// Brief    : Scoreboard bench for the 1-to-2 stream demux. Directed scenarios
//            plus a randomized phase; a queue-based model predicts each port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit32_demux1to2_stream;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready = 1'b0;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready = 1'b0;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int tests  = 0;
  int errors = 0;

  // Reference model: each port is a FIFO of words owed to its consumer, plus a transfer count.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNT_W-1:0] mc0 = '0;
  logic [CNT_W-1:0] mc1 = '0;
  logic             hold = 1'b0;

  bit32_demux1to2_stream #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs to the model mid-cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    logic exp_ready;
    logic t0;
    logic t1;
    chk("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
    chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
    if (q0.size() != 0) chk("out0_data", 64'(out0_data), 64'(q0[0]));
    if (q1.size() != 0) chk("out1_data", 64'(out1_data), 64'(q1[0]));
    chk("cnt0", 64'(cnt0), 64'(mc0));
    chk("cnt1", 64'(cnt1), 64'(mc1));
    if (rst) begin
      q0.delete();
      q1.delete();
      mc0  = '0;
      mc1  = '0;
      hold = 1'b0;
    end else begin
      exp_ready = 1'b0;
      if (in_valid) begin
        exp_ready = in_sel ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
      end
      t0 = (q0.size() != 0) && out0_ready;
      t1 = (q1.size() != 0) && out1_ready;
      if (t0) begin void'(q0.pop_front()); mc0 = mc0 + 1'b1; end
      if (t1) begin void'(q1.pop_front()); mc1 = mc1 + 1'b1; end
      if (in_valid && exp_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
      hold = in_valid && !exp_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    step();
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with in_valid held high: everything must come up empty and zero.
    do_reset();
    chk("rst_out0_valid", 64'(out0_valid), 64'd0);
    chk("rst_out1_valid", 64'(out1_valid), 64'd0);
    chk("rst_out0_data", 64'(out0_data), 64'd0);
    chk("rst_out1_data", 64'(out1_data), 64'd0);
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_cnt1", 64'(cnt1), 64'd0);

    // Single steer to port 0.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_data    = 32'hAAAAAAAA;
    in_sel     = 1'b0;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    chk("steer_out0_data", 64'(out0_data), 64'hAAAAAAAA);
    chk("steer_out0_valid", 64'(out0_valid), 64'd1);
    chk("steer_out1_valid", 64'(out1_valid), 64'd0);
    step();
    chk("steer_cnt0", 64'(cnt0), 64'd1);

    // Stall isolation: port 0 full and stalled must not block port 1.
    do_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    in_data    = 32'h12345678;
    in_sel     = 1'b0;
    in_valid   = 1'b1;
    step();
    in_data = 32'h9ABCDEF0;
    #1;
    chk("stall_ready_sel0", 64'(in_ready), 64'd0);
    in_sel  = 1'b1;
    in_data = 32'h55555555;
    #1;
    chk("stall_ready_sel1", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("stall_out1_data", 64'(out1_data), 64'h55555555);
    chk("stall_out1_valid", 64'(out1_valid), 64'd1);
    chk("stall_out0_held", 64'(out0_data), 64'h12345678);
    step();
    chk("stall_cnt1", 64'(cnt1), 64'd1);
    chk("stall_cnt0", 64'(cnt0), 64'd0);

    // Full throughput: 8 back-to-back words to port 1.
    do_reset();
    out1_ready = 1'b1;
    in_sel     = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'hC0DE0000 + 32'(i);
      #1;
      chk("thru_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("thru_cnt1", 64'(cnt1), 64'd8);

    // Alternating destinations: odd words to port 0, even words to port 1.
    do_reset();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_data = 32'(i);
      in_sel  = (i % 2 == 0);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("alt_cnt0", 64'(cnt0), 64'd3);
    chk("alt_cnt1", 64'(cnt1), 64'd3);

    // Mid-operation reset with both slots full: held words are dropped.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 32'hDEAD0000;
    step();
    in_sel  = 1'b1;
    in_data = 32'hDEAD0001;
    step();
    in_valid = 1'b0;
    chk("midrst_full0", 64'(out0_valid), 64'd1);
    chk("midrst_full1", 64'(out1_valid), 64'd1);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    chk("midrst_v0", 64'(out0_valid), 64'd0);
    chk("midrst_v1", 64'(out1_valid), 64'd0);
    step();
    chk("midrst_cnt0", 64'(cnt0), 64'd0);
    chk("midrst_cnt1", 64'(cnt1), 64'd0);

    // Counter wrap: 17 transfers on a 4-bit counter leave it at 1.
    do_reset();
    out0_ready = 1'b1;
    in_sel     = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("wrap_cnt0", 64'(cnt0), 64'd1);

    // Randomized traffic with random back-pressure; input held stable while stalled.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom);
        in_data  = $urandom;
      end
      step();
    end
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();
    step();
    step();
    chk("final_q0_empty", 64'(out0_valid), 64'd0);
    chk("final_q1_empty", 64'(out1_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule : tb_bit32_demux1to2_stream
`default_nettype wire
